// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_ACK
    } seq_state_e;

    // One counter serves both the hold window and the inter-stage gap.
    function automatic int cnt_width(input int hold_cycles, input int stage_delay);
        int m;
        m = (hold_cycles > stage_delay) ? hold_cycles : stage_delay;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release controller: holds all domain resets until PLL lock is
// stable, then releases them in index order; re-sequences on lock loss or soft request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  soft_req,
    output logic                  soft_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_released,
    output logic                  busy
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY);
    localparam int IW = $clog2(NUM_STAGES + 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] IDX_FULL   = IW'(NUM_STAGES);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          lock_sync;
    logic          advance;
    logic [IW-1:0] idx_inc;

    sync_2ff u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_sync)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        advance   = 1'b0;
        idx_inc   = idx_q + IW'(1);

        case (state_q)
            ST_HOLD: begin
                idx_d = '0;
                if (!lock_sync)
                    cnt_d = '0;
                else if (cnt_q == HOLD_LAST)
                    advance = 1'b1;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            ST_RELEASE: begin
                if (!lock_sync) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                // A request coinciding with lock loss is remembered so it is still acked.
                if (!lock_sync || soft_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    if (soft_req)
                        pending_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (!lock_sync) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (!soft_req) begin
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (advance) begin
            cnt_d = '0;
            idx_d = idx_inc;
            if (idx_inc == IDX_FULL)
                state_d = pending_q ? ST_ACK : ST_RUN;
            else
                state_d = ST_RELEASE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Thermometer decode: stage k is out of reset once k stages precede the index.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        assign stage_rst_n[k] = (idx_q > IW'(k));
    end

    assign all_released = (idx_q == IDX_FULL);
    assign busy         = (state_q == ST_HOLD) || (state_q == ST_RELEASE);
    assign soft_ack     = (state_q == ST_ACK);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_lock;
    logic       soft_req;
    logic       soft_ack;
    logic [3:0] stage_rst_n;
    logic       all_released;
    logic       busy;

    int nvec = 0;
    int nmis = 0;

    reset_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .soft_req     (soft_req),
        .soft_ack     (soft_ack),
        .stage_rst_n  (stage_rst_n),
        .all_released (all_released),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stage k is released at edge t0 + 8k.
    function automatic logic [3:0] mask_at(input int n, input int t0);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (n >= t0 + 8 * k);
        return m;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] m, input logic ar,
                           input logic bz, input logic ak);
        chk({tag, ".rst_n"}, 32'(stage_rst_n), 32'(m));
        chk({tag, ".all_rel"}, 32'(all_released), 32'(ar));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".ack"}, 32'(soft_ack), 32'(ak));
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b1;
        soft_req = 1'b0;
        #12;
        chk_all("in_reset", 4'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Power-up: stages at 18, 26, 34, 42.
        for (int n = 1; n <= 50; n++) begin
            tick();
            chk_all("pwrup", mask_at(n, 18), n >= 42, n < 42, 1'b0);
        end

        // Soft reset held high through the whole sequence, then dropped.
        soft_req = 1'b1;
        for (int r = 0; r <= 45; r++) begin
            tick();
            chk_all("soft", mask_at(r, 16), r >= 40, r < 40, r >= 40);
        end
        soft_req = 1'b0;
        tick();
        chk_all("soft_drop", 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("soft_run", 4'hF, 1'b1, 1'b0, 1'b0);

        // One-cycle lock loss in RUN: resets assert on the third edge.
        pll_lock = 1'b0;
        tick();
        chk_all("lockrun_f1", 4'hF, 1'b1, 1'b0, 1'b0);
        pll_lock = 1'b1;
        tick();
        chk_all("lockrun_f2", 4'hF, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r <= 42; r++) begin
            tick();
            chk_all("lockrun", mask_at(r, 16), r >= 40, r < 40, 1'b0);
        end

        // Park in HOLD with lock low, then flicker lock after 10 good counts.
        pll_lock = 1'b0;
        tick();
        tick();
        tick();
        chk_all("hold_entry", 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk_all("hold_wait", 4'h0, 1'b0, 1'b1, 1'b0);
        pll_lock = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            tick();
            chk_all("flicker", mask_at(n, 31), n >= 55, n < 55, 1'b0);
            if (n == 12) pll_lock = 1'b0;
            if (n == 13) pll_lock = 1'b1;
        end

        // Lock loss while acking with soft_req still high: ack reissued.
        soft_req = 1'b1;
        for (int r = 0; r <= 40; r++) begin
            tick();
            chk_all("ack_seq", mask_at(r, 16), r >= 40, r < 40, r >= 40);
        end
        pll_lock = 1'b0;
        tick();
        chk_all("ack_f1", 4'hF, 1'b1, 1'b0, 1'b1);
        pll_lock = 1'b1;
        tick();
        chk_all("ack_f2", 4'hF, 1'b1, 1'b0, 1'b1);
        for (int r = 0; r <= 41; r++) begin
            tick();
            chk_all("ack_relock", mask_at(r, 16), r >= 40, r < 40, r >= 40);
        end
        soft_req = 1'b0;
        tick();
        chk_all("ack_drop", 4'hF, 1'b1, 1'b0, 1'b0);

        // soft_req and lock loss seen on the same RUN edge.
        pll_lock = 1'b0;
        tick();
        chk_all("simul_f1", 4'hF, 1'b1, 1'b0, 1'b0);
        pll_lock = 1'b1;
        tick();
        chk_all("simul_f2", 4'hF, 1'b1, 1'b0, 1'b0);
        soft_req = 1'b1;
        for (int r = 0; r <= 40; r++) begin
            tick();
            chk_all("simul", mask_at(r, 16), r >= 40, r < 40, r >= 40);
        end
        soft_req = 1'b0;
        tick();
        chk_all("simul_drop", 4'hF, 1'b1, 1'b0, 1'b0);

        // Reset asserted between edges with stage 1 released.
        soft_req = 1'b1;
        for (int r = 0; r <= 25; r++) begin
            tick();
            chk_all("pre_rst", mask_at(r, 16), 1'b0, 1'b1, 1'b0);
        end
        chk("pre_rst.stage1", 32'(stage_rst_n), 32'h3);
        soft_req = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("rst_held", 4'h0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int n = 1; n <= 44; n++) begin
            tick();
            chk_all("repwr", mask_at(n, 18), n >= 42, n < 42, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
